shift_sequencer: RTL and testbench

//  Multi-cycle shift controller placed directly upstream of the 8-bit barrel

---
 rtl/shift_sequencer_if.sv | 32 +++
 rtl/shift_sequencer.sv | 116 +++++++++++
 tb/tb_shift_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Command, shifter-loop and result signals of the shift sequencer.
// slave = sequencer view, master = surrounding logic / bench view.
// in_* and out_* are valid/ready pairs; sh_* is the combinational shifter loop.
interface shift_sequencer_if #(
    parameter int AMT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_lr;
    logic             in_al;
    logic [7:0]       sh_din;
    logic [2:0]       sh_shamt;
    logic             sh_lr;
    logic             sh_al;
    logic [7:0]       sh_dout;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             busy;

    modport slave (
        input  in_valid, in_data, in_amt, in_lr, in_al, sh_dout, out_ready,
        output in_ready, sh_din, sh_shamt, sh_lr, sh_al, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_amt, in_lr, in_al, sh_dout, out_ready,
        input  in_ready, sh_din, sh_shamt, sh_lr, sh_al, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// Splits a wide shift into <=STEP_MAX steps through an external 8-bit barrel shifter.
// Latency: ceil(amt/STEP_MAX)+1 edges from accept to out_valid (1 edge for amt=0).
// Backpressure: result held in DONE until out_ready; no new command accepted meanwhile.
module shift_sequencer #(
    parameter int AMT_W    = 5,   // must be >= 3
    parameter int STEP_MAX = 7    // must be <= 7
) (
    input  logic               clk,
    input  logic               rst,
    shift_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] LP_STEP_MAX = AMT_W'(STEP_MAX);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_acc;
    logic [7:0]       r_out;
    logic [AMT_W-1:0] r_rem;
    logic             r_lr;
    logic             r_al;

    logic [2:0]       w_step;
    logic [AMT_W-1:0] w_rem_nxt;
    logic             w_last;
    logic             w_accept;

    // Current step is the remaining amount clamped to STEP_MAX; w_last marks the final step.
    always_comb begin
        w_step    = (r_rem > LP_STEP_MAX) ? 3'(STEP_MAX) : r_rem[2:0];
        w_rem_nxt = r_rem - AMT_W'(w_step);
        w_last    = (w_rem_nxt == '0);
        w_accept  = (r_state == S_IDLE) && bus.in_valid;
    end

    // State register; reset wins over any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/shifter-control outputs.
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.sh_shamt  = 3'd0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = (bus.in_amt != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                bus.busy     = 1'b1;
                bus.sh_shamt = w_step;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: latch the command on accept, fold each shifter result back into acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 8'h00;
            r_rem <= '0;
            r_lr  <= 1'b0;
            r_al  <= 1'b0;
            r_out <= 8'h00;
        end else if (w_accept) begin
            r_acc <= bus.in_data;
            r_rem <= bus.in_amt;
            r_lr  <= bus.in_lr;
            r_al  <= bus.in_al;
            // A zero-length shift bypasses the shifter entirely.
            if (bus.in_amt == '0) begin
                r_out <= bus.in_data;
            end
        end else if (r_state == S_RUN) begin
            r_acc <= bus.sh_dout;
            r_rem <= w_rem_nxt;
            if (w_last) begin
                r_out <= bus.sh_dout;
            end
        end
    end

    assign bus.sh_din   = r_acc;
    assign bus.sh_lr    = r_lr;
    assign bus.sh_al    = r_al;
    assign bus.out_data = r_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed commands, expected results and shift steps
// queued at issue time and checked by an independent monitor on the negedge.
module tb_shift_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_sequencer_if #(.AMT_W(5)) bus ();

    shift_sequencer #(.AMT_W(5), .STEP_MAX(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural 8-bit barrel shifter closing the loop.
    always_comb begin
        if (bus.sh_lr)      bus.sh_dout = bus.sh_din << bus.sh_shamt;
        else if (bus.sh_al) bus.sh_dout = 8'($signed(bus.sh_din) >>> bus.sh_shamt);
        else                bus.sh_dout = bus.sh_din >> bus.sh_shamt;
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] q_res[$];
    int         q_sh[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: pops a step for every RUN cycle and a result for every output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.busy && !bus.out_valid) begin
                if (q_sh.size() == 0) fail_evt("unexpected_run_step");
                else chk("sh_shamt", 32'(bus.sh_shamt), q_sh.pop_front());
            end
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (q_res.size() == 0) fail_evt("unexpected_result");
                else chk("out_data", 32'(bus.out_data), 32'(q_res.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_idle(input string nm);
        chk({nm, "_in_ready"},  32'(bus.in_ready), 1);
        chk({nm, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({nm, "_out_data"},  32'(bus.out_data), 0);
        chk({nm, "_busy"},      32'(bus.busy), 0);
        chk({nm, "_sh_shamt"},  32'(bus.sh_shamt), 0);
    endtask

    // steps: one hex digit per expected shamt, first step in the most significant used digit.
    task automatic send(input string nm, input logic [7:0] d, input logic [4:0] amt,
                        input logic lr, input logic al, input logic [31:0] steps,
                        input int nsteps, input logic [7:0] exp, input int exp_lat,
                        input int stall);
        int w;
        int lat;
        for (int i = 0; i < nsteps; i++) q_sh.push_back(int'(steps[4*(nsteps-1-i) +: 4]));
        q_res.push_back(exp);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amt    = amt;
        bus.in_lr     = lr;
        bus.in_al     = al;
        bus.out_ready = (stall == 0);
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) fail_evt({nm, "_accept_timeout"});
        @(posedge clk);
        #1;
        // Scramble the command inputs; the latched copy must be used.
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
        bus.in_amt   = amt ^ 5'h15;
        bus.in_lr    = ~lr;
        bus.in_al    = ~al;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_shamt_done"}, 32'(bus.sh_shamt), 0);
        if (stall > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hA5;
            bus.in_amt   = 5'd1;
            repeat (stall) begin
                @(negedge clk);
                chk({nm, "_stall_data"},     32'(bus.out_data), 32'(exp));
                chk({nm, "_stall_in_ready"}, 32'(bus.in_ready), 0);
                chk({nm, "_stall_valid"},    32'(bus.out_valid), 1);
            end
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        w = 0;
        while (bus.out_valid && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 50) fail_evt({nm, "_drain_timeout"});
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_amt    = 5'd0;
        bus.in_lr     = 1'b0;
        bus.in_al     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        //   name       data   amt    lr    al    steps        n  exp    lat stall
        send("rlog_f0", 8'hF0, 5'd4,  1'b0, 1'b0, 32'h4,       1, 8'h0F, 2, 0);
        send("rari_81", 8'h81, 5'd9,  1'b0, 1'b1, 32'h72,      2, 8'hFF, 3, 0);
        send("left_ff", 8'hFF, 5'd31, 1'b1, 1'b0, 32'h77773,   5, 8'h00, 6, 0);
        send("left_03", 8'h03, 5'd6,  1'b1, 1'b0, 32'h6,       1, 8'hC0, 2, 0);
        send("zero_5a", 8'h5A, 5'd0,  1'b0, 1'b0, 32'h0,       0, 8'h5A, 1, 0);
        send("rlog_80", 8'h80, 5'd8,  1'b0, 1'b0, 32'h71,      2, 8'h00, 3, 0);
        send("rari_80", 8'h80, 5'd3,  1'b0, 1'b1, 32'h3,       1, 8'hF0, 2, 0);
        send("rari_40", 8'h40, 5'd6,  1'b0, 1'b1, 32'h6,       1, 8'h01, 2, 0);
        send("rari_7f", 8'h7F, 5'd14, 1'b0, 1'b1, 32'h77,      2, 8'h00, 3, 0);
        send("left_al", 8'h01, 5'd7,  1'b1, 1'b1, 32'h7,       1, 8'h80, 2, 0);
        send("stall_3c",8'h3C, 5'd2,  1'b0, 1'b0, 32'h2,       1, 8'h0F, 2, 3);

        // Reset in the middle of a 5-step run: only two steps are observed, no result.
        q_sh.push_back(7);
        q_sh.push_back(7);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.in_amt   = 5'd31;
        bus.in_lr    = 1'b1;
        bus.in_al    = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("midrun_rst");
        chk("midrun_steps_left", 32'(q_sh.size()), 0);
        rst = 1'b0;

        send("post_rst",8'h96, 5'd1,  1'b1, 1'b0, 32'h1,       1, 8'h2C, 2, 0);

        repeat (3) @(posedge clk);
        chk("results_left", 32'(q_res.size()), 0);
        chk("steps_left",   32'(q_sh.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
